// File: rtl/facto_regif.sv
// facto_regif: bus-slave register file for the factorial accelerator.
// Seven address windows hold the START, CLEAR, DONE, INTREN, OPERAND,
// RESULT_H and RESULT_L registers. The block also produces the start and
// clear pulses for the core, tracks busy/done, and raises the interrupt.
module facto_regif #(
   parameter int                DATA_W    = 64,
   parameter int                ADDR_W    = 8,
   parameter int                WIN_SHIFT = 3,
   parameter logic [ADDR_W-1:0] BASE      = '0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                s_sel,
   input  logic                s_wr,
   input  logic [ADDR_W-1:0]   s_addr,
   input  logic [DATA_W-1:0]   s_din,
   output logic [DATA_W-1:0]   s_dout,
   output logic                op_start,
   output logic                op_clear,
   output logic [DATA_W-1:0]   operand,
   input  logic                done_i,
   input  logic [2*DATA_W-1:0] result_i,
   output logic                busy,
   output logic                interrupt
);

   // Window indices after subtracting BASE and dropping the in-window byte bits
   localparam logic [ADDR_W-1:0] IDX_START   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] IDX_CLEAR   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] IDX_DONE    = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] IDX_INTREN  = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] IDX_OPERAND = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] IDX_RES_H   = ADDR_W'(5);
   localparam logic [ADDR_W-1:0] IDX_RES_L   = ADDR_W'(6);

   logic              r_busy;
   logic              r_done;
   logic              r_intren;
   logic              r_start;
   logic              r_clear;
   logic [DATA_W-1:0] r_operand;
   logic [DATA_W-1:0] r_res_h;
   logic [DATA_W-1:0] r_res_l;
   logic [DATA_W-1:0] r_dout;

   logic [ADDR_W:0]   w_diff;
   logic [ADDR_W-1:0] w_idx;
   logic              w_valid;
   logic              w_wr;
   logic              w_start;
   logic              w_clear;
   logic              w_complete;
   logic              w_operand_wr;
   logic              w_intren_wr;
   logic [DATA_W-1:0] w_rdata;

   // The extra top bit of the subtraction is the borrow, set when s_addr < BASE
   assign w_diff  = {1'b0, s_addr} - {1'b0, BASE};
   assign w_idx   = w_diff[ADDR_W-1:0] >> WIN_SHIFT;
   assign w_valid = ~w_diff[ADDR_W] && (w_idx <= IDX_RES_L);

   assign w_wr         = s_sel && s_wr && w_valid;
   assign w_start      = w_wr && (w_idx == IDX_START) && s_din[0] && !r_busy;
   assign w_clear      = w_wr && (w_idx == IDX_CLEAR) && s_din[0];
   // A clear in the same cycle wins over completion, so nothing is captured
   assign w_complete   = done_i && r_busy && !w_clear;
   assign w_operand_wr = w_wr && (w_idx == IDX_OPERAND) && !r_busy;
   assign w_intren_wr  = w_wr && (w_idx == IDX_INTREN);

   // Read-data mux over the current register values
   always_comb begin
      // NOTE: default assigned first so every path drives w_rdata and no latch is inferred
      w_rdata = '0;
      if (s_sel && !s_wr && w_valid) begin
         case (w_idx)
            IDX_DONE:    w_rdata[1:0] = {r_busy, r_done};
            IDX_INTREN:  w_rdata[0]   = r_intren;
            IDX_OPERAND: w_rdata      = r_operand;
            IDX_RES_H:   w_rdata      = r_res_h;
            IDX_RES_L:   w_rdata      = r_res_l;
            default:     w_rdata      = '0;
         endcase
      end
   end

   // Operation control: busy/done tracking and the one-cycle core pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_start <= 1'b0;
         r_clear <= 1'b0;
      end else begin
         r_start <= w_start;
         r_clear <= w_clear;
         if (w_clear) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
         end else if (w_start) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
         end else if (w_complete) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end
      end
   end

   // Data registers: operand, interrupt enable, captured result, read data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_operand <= '0;
         r_intren  <= 1'b0;
         r_res_h   <= '0;
         r_res_l   <= '0;
         r_dout    <= '0;
      end else begin
         r_dout <= w_rdata;
         if (w_operand_wr) r_operand <= s_din;
         if (w_intren_wr)  r_intren  <= s_din[0];
         if (w_clear) begin
            r_res_h <= '0;
            r_res_l <= '0;
         end else if (w_complete) begin
            r_res_h <= result_i[2*DATA_W-1:DATA_W];
            r_res_l <= result_i[DATA_W-1:0];
         end
      end
   end

   assign s_dout    = r_dout;
   assign op_start  = r_start;
   assign op_clear  = r_clear;
   assign operand   = r_operand;
   assign busy      = r_busy;
   assign interrupt = r_done & r_intren;

endmodule

// File: doc/facto_regif.md
# facto_regif

Parametrised, registered bus-slave register interface for the factorial accelerator. It is the successor to the pure address decoder. It decodes the slave address into seven register windows and holds the control, status, operand and result registers. It generates start/clear pulses to the core, tracks busy/done state and raises the interrupt. It sits between the system bus slave port and the factorial datapath.

## Interface
- DATA_W, 64, operand and result-half width in bits
- ADDR_W, 8, slave address width
- WIN_SHIFT, 3, log2 of window size in bytes (default 8-byte windows)
- BASE, 0, first address of window 0; must be a multiple of 2^WIN_SHIFT
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- s_sel  input  1  slave select
- s_wr  input  1  1 = write, 0 = read (qualified by s_sel)
- s_addr  input  ADDR_W  byte address
- s_din  input  DATA_W  write data
- s_dout  output  DATA_W  registered read data
- op_start  output  1  one-cycle start pulse to core
- op_clear  output  1  one-cycle clear pulse to core
- operand  output  DATA_W  operand register contents
- done_i  input  1  core completion pulse (one cycle)
- result_i  input  2*DATA_W  core result, valid in the cycle done_i=1
- busy  output  1  operation in progress
- interrupt  output  1  done & intren

## Operation
- Decode: off = s_addr - BASE (ADDR_W bits); idx = off >> WIN_SHIFT. The access is valid iff s_addr >= BASE and idx <= 6. Low WIN_SHIFT address bits are ignored.
- idx0 START (W):
  - Write with s_din[0]=1 while busy=0 makes op_start=1 for exactly the next cycle and sets busy.
  - Write while busy=1 is ignored. Reads return 0.
- idx1 CLEAR (W):
  - Write with s_din[0]=1 makes op_clear=1 next cycle.
  - Clears busy, done, result_h and result_l. Operand and intren are kept. Reads return 0.
- idx2 DONE (RO): bit0 = done, bit1 = busy, other bits 0.
- idx3 INTREN (RW): bit0 only; other bits read 0.
- idx4 OPERAND (RW, DATA_W): writes are ignored while busy=1.
- idx5 RESULT_H (RO): captured result_i[2*DATA_W-1:DATA_W].
- idx6 RESULT_L (RO): captured result_i[DATA_W-1:0].
- Writes to read-only or invalid addresses are ignored.
- Reads of invalid addresses return 0.
- Completion: when done_i=1 and busy=1:
  - Capture both result halves.
  - Set done, clear busy.
  - done_i while busy=0 is ignored.
- Starting a new operation clears done.
- interrupt = done & intren, combinational from registers (glitch-free).
- Priorities in one cycle:
  - Clear write beats done_i. The result is not captured and done stays 0.
  - A clear write takes effect regardless of busy.

## Timing
- Reset (async, reset_n=0) zeroes:
  - s_dout, op_start, op_clear, operand, busy, done, intren, result_h, result_l, interrupt.
- Write: sampled at the rising edge where s_sel=1 and s_wr=1. The register updates at that edge.
- Read: at the edge where s_sel=1 and s_wr=0, s_dout loads the addressed value. It is visible one cycle after the request.
  - Every other edge loads s_dout with 0.
  - Back-to-back reads are supported at one per cycle.
- Read of DONE in the same cycle as done_i returns the pre-update value. The new value is visible on the following read.
- op_start and op_clear: high exactly one cycle, in the cycle after the write edge.
- busy rises at the write edge of START, concurrent with op_start. It falls at the edge sampling done_i.
- Reset asserted mid-operation: busy, done and pulses drop immediately. A later done_i without a new start is ignored.

## Test plan
- Reset, then read all 7 windows:
  - s_dout is 0 in every reply.
  - busy, interrupt, op_start and op_clear are 0.
- Write OPERAND=5 at 0x20, read 0x27:
  - s_dout=5 one cycle after the read.
  - Read of 0x38 returns 0; read of 0xFF returns 0.
- Write START (0x00, din=1):
  - op_start high for one cycle and busy=1.
  - OPERAND write of 9 is ignored (read back 5).
  - Second START produces no pulse.
- With INTREN=1, pulse done_i with result_i={64'h0,64'd120}:
  - busy=0, DONE read = 1, interrupt=1.
  - RESULT_L=120, RESULT_H=0.
- Same cycle: CLEAR write (0x08) and done_i:
  - done=0, results stay 0, interrupt=0.
  - op_clear pulses one cycle.
- BASE=8'h40, WIN_SHIFT=4 instance:
  - 0x50 decodes to CLEAR.
  - 0x3F is invalid and returns 0.
  - 0xA0 (idx6) reads RESULT_L.
